// File: rtl/sbox_share_ctrl.sv
// Round-robin arbiter/sequencer that time-shares one pipelined byte S-box between two
// 32-bit SubWord requesters, tracking in-flight bytes and reassembling the result word.
module sbox_share_ctrl #(
  parameter int unsigned LAT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [31:0] word0,
  input  logic        req1,
  input  logic [31:0] word1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        busy,
  output logic [7:0]  sbox_in,
  output logic        sbox_valid,
  input  logic [7:0]  sbox_out
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned DEPTH  = (LAT == 0) ? 1 : LAT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     cnt_q, cnt_d;
  logic [NBYTES-1:0][BYTE_W-1:0]        word_q, word_d;
  logic [NBYTES-1:0][BYTE_W-1:0]        stage_q, stage_d;
  logic                                 gid_q, gid_d;
  logic                                 last_q, last_d;
  logic [DEPTH-1:0]                     trk_vld_q, trk_vld_d;
  logic [DEPTH-1:0][IDX_W-1:0]          trk_idx_q, trk_idx_d;
  logic [NBYTES*BYTE_W-1:0]             result_q, result_d;
  logic                                 done0_q, done0_d;
  logic                                 done1_q, done1_d;
  logic                                 busy_q, busy_d;
  logic                                 sbox_valid_q, sbox_valid_d;
  logic [BYTE_W-1:0]                    sbox_in_q, sbox_in_d;

  logic                                 issuing;
  logic                                 cap_vld;
  logic [IDX_W-1:0]                     cap_idx;
  logic                                 grant_any;
  logic                                 grant_id;

  // Capture source: with no pipeline the byte being issued returns in the same cycle
  always_comb begin
    issuing = (state_q == S_ISSUE);
    if (LAT == 0) begin
      cap_vld = issuing;
      cap_idx = cnt_q;
    end else begin
      cap_vld = trk_vld_q[DEPTH-1];
      cap_idx = trk_idx_q[DEPTH-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    stage_d      = stage_q;
    gid_d        = gid_q;
    last_d       = last_q;
    trk_vld_d    = trk_vld_q;
    trk_idx_d    = trk_idx_q;
    result_d     = result_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    sbox_valid_d = 1'b0;
    sbox_in_d    = '0;
    grant_any    = req0 | req1;
    grant_id     = (req0 && req1) ? ~last_q : req1;

    trk_vld_d[0] = issuing;
    trk_idx_d[0] = cnt_q;
    for (int i = 1; i < int'(DEPTH); i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_idx_d[i] = trk_idx_q[i-1];
    end

    if (cap_vld) begin
      stage_d[cap_idx] = sbox_out;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          gid_d        = grant_id;
          last_d       = grant_id;
          word_d       = grant_id ? word1 : word0;
          cnt_d        = '0;
          stage_d      = '0;
          sbox_valid_d = 1'b1;
          sbox_in_d    = word_d[0];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = IDX_W'(cnt_q + 1'b1);
        if (cnt_q != IDX_W'(NBYTES - 1)) begin
          sbox_valid_d = 1'b1;
          sbox_in_d    = word_q[cnt_d];
        end else begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cap_vld && (cap_idx == IDX_W'(NBYTES - 1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result and done are loaded on DONE entry so they appear in the DONE cycle itself
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      result_d = stage_d;
      done0_d  = ~gid_q;
      done1_d  = gid_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      stage_q      <= '0;
      gid_q        <= 1'b0;
      last_q       <= 1'b1;
      trk_vld_q    <= '0;
      trk_idx_q    <= '0;
      result_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      sbox_valid_q <= 1'b0;
      sbox_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      stage_q      <= stage_d;
      gid_q        <= gid_d;
      last_q       <= last_d;
      trk_vld_q    <= trk_vld_d;
      trk_idx_q    <= trk_idx_d;
      result_q     <= result_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
      sbox_valid_q <= sbox_valid_d;
      sbox_in_q    <= sbox_in_d;
    end
  end

  assign done0      = done0_q;
  assign done1      = done1_q;
  assign result     = result_q;
  assign busy       = busy_q;
  assign sbox_in    = sbox_in_q;
  assign sbox_valid = sbox_valid_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: one LAT=3 instance and one LAT=0 instance, each fed
// by a small behavioural S-box model that knows the handful of bytes used here.
module tb_sbox_share_ctrl;

  logic        clk;
  logic        reset_n;

  logic        req0, req1;
  logic [31:0] word0, word1;
  logic        done0, done1, busy, sbox_valid;
  logic [31:0] result;
  logic [7:0]  sbox_in, sbox_out;

  logic        z_req0, z_req1;
  logic [31:0] z_word0, z_word1;
  logic        z_done0, z_done1, z_busy, z_sbox_valid;
  logic [31:0] z_result;
  logic [7:0]  z_sbox_in, z_sbox_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] word;
    logic [31:0] other;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [5];

  sbox_share_ctrl #(.LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .word0(word0), .req1(req1), .word1(word1),
    .done0(done0), .done1(done1), .result(result), .busy(busy),
    .sbox_in(sbox_in), .sbox_valid(sbox_valid), .sbox_out(sbox_out)
  );

  sbox_share_ctrl #(.LAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0(z_req0), .word0(z_word0), .req1(z_req1), .word1(z_word1),
    .done0(z_done0), .done1(z_done1), .result(z_result), .busy(z_busy),
    .sbox_in(z_sbox_in), .sbox_valid(z_sbox_valid), .sbox_out(z_sbox_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    case (x)
      8'h00:   sbox_f = 8'h63;
      8'h01:   sbox_f = 8'h7C;
      8'h02:   sbox_f = 8'h77;
      8'h03:   sbox_f = 8'h7B;
      8'h53:   sbox_f = 8'hED;
      8'hFF:   sbox_f = 8'h16;
      default: sbox_f = x ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] pipe [3];
  always @(posedge clk) begin
    pipe[0] <= sbox_f(sbox_in);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign sbox_out   = pipe[2];
  assign z_sbox_out = sbox_f(z_sbox_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at the negedge of an IDLE cycle (cycle 0); returns at the negedge of cycle 9
  task automatic run_op(input logic id, input logic [31:0] w, input logic [31:0] other,
                        input logic [31:0] res_exp, input bit perturb, input string tag);
    logic [7:0] eb;
    logic       ev;
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    req0  = (id == 1'b0);
    req1  = (id == 1'b1);
    word0 = id ? other : w;
    word1 = id ? w : other;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      ev = (c >= 1) && (c <= 4);
      eb = 8'h00;
      if (ev) eb = w[8*(c-1) +: 8];
      chk({tag, " sbox_valid"}, 32'(sbox_valid), 32'(ev));
      chk({tag, " sbox_in"}, 32'(sbox_in), 32'(eb));
      chk({tag, " busy"}, 32'(busy), 32'(c <= 8));
      chk({tag, " done0"}, 32'(done0), 32'((c == 8) && (id == 1'b0)));
      chk({tag, " done1"}, 32'(done1), 32'((c == 8) && (id == 1'b1)));
      if (c == 8) begin
        chk({tag, " result"}, result, res_exp);
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (perturb && c == 2) begin
        if (id) word1 = 32'hFFFF_FFFF;
        else    word0 = 32'hFFFF_FFFF;
      end
      if (perturb && c == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{id: 1'b0, word: 32'h0302_0100, other: 32'hDEAD_BEEF, res: 32'h7B77_7C63};
    vecs[1] = '{id: 1'b1, word: 32'h0302_0100, other: 32'h0000_0000, res: 32'h7B77_7C63};
    vecs[2] = '{id: 1'b0, word: 32'h53FF_0100, other: 32'h0000_0000, res: 32'hED16_7C63};
    vecs[3] = '{id: 1'b1, word: 32'h0000_00FF, other: 32'hFFFF_FFFF, res: 32'h6363_6316};
    vecs[4] = '{id: 1'b0, word: 32'h0153_FF02, other: 32'h0000_0000, res: 32'h7CED_1677};

    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; word0 = '0; word1 = '0;
    z_req0 = 1'b0; z_req1 = 1'b0; z_word0 = '0; z_word1 = '0;
    repeat (2) @(negedge clk);
    chk("rst done0", 32'(done0), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst sbox_valid", 32'(sbox_valid), 32'd0);
    chk("rst sbox_in", 32'(sbox_in), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst lat0 busy", 32'(z_busy), 32'd0);
    chk("rst lat0 result", z_result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].id, vecs[i].word, vecs[i].other, vecs[i].res, 1'b0, $sformatf("vec%0d", i));
    end

    // Operand and request changes after grant must not disturb the operation
    run_op(1'b0, 32'h0302_0100, 32'h0000_0000, 32'h7B77_7C63, 1'b1, "perturb");

    // Reset during ISSUE, then a fresh request from requester 1
    do_reset();
    req0  = 1'b1;
    word0 = 32'h0302_0100;
    @(negedge clk);
    @(negedge clk);
    chk("abort mid sbox_valid", 32'(sbox_valid), 32'd1);
    chk("abort mid sbox_in", 32'(sbox_in), 32'h01);
    reset_n = 1'b0;
    req0    = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort sbox_valid", 32'(sbox_valid), 32'd0);
    chk("abort sbox_in", 32'(sbox_in), 32'd0);
    chk("abort done0", 32'(done0), 32'd0);
    reset_n = 1'b1;
    run_op(1'b1, 32'h0153_FF02, 32'hA5A5_A5A5, 32'h7CED_1677, 1'b0, "post_abort");

    // Both held high: tie goes to 0 after reset, then grants alternate every 9 cycles
    do_reset();
    req0  = 1'b1;
    req1  = 1'b1;
    word0 = 32'h0000_00FF;
    word1 = 32'h0000_0053;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      chk($sformatf("alt c%0d done0", c), 32'(done0), 32'((c % 18) == 8));
      chk($sformatf("alt c%0d done1", c), 32'(done1), 32'((c % 18) == 17));
      if ((c % 18) == 8)  chk($sformatf("alt c%0d result", c), result, 32'h6363_6316);
      if ((c % 18) == 17) chk($sformatf("alt c%0d result", c), result, 32'h6363_63ED);
      if (c == 1)  chk("alt first byte", 32'(sbox_in), 32'hFF);
      if (c == 10) chk("alt second grant byte", 32'(sbox_in), 32'h53);
      if (c == 35) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("alt end busy", 32'(busy), 32'd0);

    // Zero-latency instance: done at cycle 5
    z_req1  = 1'b1;
    z_word1 = 32'h53FF_0100;
    for (int c = 1; c <= 6; c++) begin
      logic       ev;
      logic [7:0] eb;
      @(negedge clk);
      ev = (c <= 4);
      eb = 8'h00;
      if (ev) eb = z_word1[8*(c-1) +: 8];
      chk($sformatf("lat0 c%0d sbox_valid", c), 32'(z_sbox_valid), 32'(ev));
      chk($sformatf("lat0 c%0d sbox_in", c), 32'(z_sbox_in), 32'(eb));
      chk($sformatf("lat0 c%0d busy", c), 32'(z_busy), 32'(c <= 5));
      chk($sformatf("lat0 c%0d done1", c), 32'(z_done1), 32'(c == 5));
      chk($sformatf("lat0 c%0d done0", c), 32'(z_done0), 32'd0);
      if (c == 5) begin
        chk("lat0 result", z_result, 32'hED16_7C63);
        z_req1 = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
